// File: rtl/lcd_refresh_scheduler.sv
// lcd_refresh_scheduler
// Decides when an LCD frame refresh is issued. Triggers come from a manual
// request pulse or from a free-running period counter; they are collapsed
// into a single pending bit and serviced one frame at a time. The block
// watches the controller's busy handshake, counts completed frames and
// flags lost triggers (overrun) and handshake timeouts (fault).
module lcd_refresh_scheduler #(
    parameter int RefreshPeriodCount = 30000,
    parameter int StartTimeoutCount  = 16,
    parameter int FrameTimeoutCount  = 65535,
    parameter int FrameCountWidth    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       request,
    input  logic                       clear,
    input  logic                       lcd_configuring,
    input  logic                       lcd_running,
    input  logic                       lcd_busy,
    output logic                       refresh,
    output logic                       frame_done,
    output logic [FrameCountWidth-1:0] frame_count,
    output logic                       overrun,
    output logic                       fault,
    output logic                       ready
);

    // One shared timer serves both handshake phases, so it is sized for
    // whichever timeout is longer.
    localparam int TimerMax = (StartTimeoutCount > FrameTimeoutCount) ?
                              StartTimeoutCount : FrameTimeoutCount;
    localparam int TimerW   = $clog2(TimerMax + 1);
    localparam int PeriodW  = $clog2(RefreshPeriodCount + 1);

    localparam logic [TimerW-1:0]  StartLoad  = TimerW'(StartTimeoutCount - 1);
    localparam logic [TimerW-1:0]  FrameLoad  = TimerW'(FrameTimeoutCount - 1);
    localparam logic [PeriodW-1:0] PeriodLoad = PeriodW'(RefreshPeriodCount - 1);

    typedef enum logic [2:0] {
        ST_WAIT_RUNNING = 3'd0,
        ST_IDLE         = 3'd1,
        ST_REQUEST      = 3'd2,
        ST_START        = 3'd3,
        ST_BUSY         = 3'd4
    } state_t;

    state_t                     r_state;
    logic [TimerW-1:0]          r_timer;
    logic [PeriodW-1:0]         r_period;
    logic                       r_pending;
    logic                       r_refresh;
    logic                       r_frame_done;
    logic [FrameCountWidth-1:0] r_frame_count;
    logic                       r_overrun;
    logic                       r_fault;

    logic w_lost_running;
    logic w_period_run;
    logic w_auto;
    logic w_trigger;
    logic w_consume;
    logic w_start_timeout;
    logic w_frame_timeout;
    logic w_fault_set;
    logic w_overrun_set;

    // The controller leaving the running state pre-empts everything except
    // the initial wait, where it is exactly what is being waited on.
    assign w_lost_running = (r_state != ST_WAIT_RUNNING) &&
                            (!lcd_running || lcd_configuring);

    // Period counter only advances while enabled and the controller is usable.
    assign w_period_run = enable && (r_state != ST_WAIT_RUNNING) && !w_lost_running;
    assign w_auto       = w_period_run && (r_period == '0);
    assign w_trigger    = request || w_auto;

    // Idle hands the pending trigger over to the Request state this cycle.
    assign w_consume = (r_state == ST_IDLE) && r_pending && !w_lost_running;

    assign w_start_timeout = (r_state == ST_START) && !lcd_busy && (r_timer == '0);
    assign w_frame_timeout = (r_state == ST_BUSY)  &&  lcd_busy && (r_timer == '0);
    assign w_fault_set     = !w_lost_running && (w_start_timeout || w_frame_timeout);

    // A trigger that finds the pending bit already occupied is merged away.
    assign w_overrun_set = !w_lost_running && w_trigger && r_pending && !w_consume;

    // Main sequencer: state, handshake timer and registered frame outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_WAIT_RUNNING;
            r_timer       <= '0;
            r_refresh     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_refresh    <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_lost_running) begin
                r_state <= ST_WAIT_RUNNING;
                r_timer <= '0;
            end else begin
                case (r_state)
                    ST_WAIT_RUNNING: begin
                        if (lcd_running && !lcd_configuring && !lcd_busy) begin
                            r_state <= ST_IDLE;
                            r_timer <= '0;
                        end
                    end
                    ST_IDLE: begin
                        if (r_pending) begin
                            r_state   <= ST_REQUEST;
                            r_refresh <= 1'b1;
                            r_timer   <= '0;
                        end
                    end
                    ST_REQUEST: begin
                        r_state <= ST_START;
                        r_timer <= StartLoad;
                    end
                    ST_START: begin
                        if (lcd_busy) begin
                            r_state <= ST_BUSY;
                            r_timer <= FrameLoad;
                        end else if (r_timer == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (!lcd_busy) begin
                            r_state       <= ST_IDLE;
                            r_timer       <= '0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + FrameCountWidth'(1);
                        end else if (r_timer == '0) begin
                            r_state <= ST_WAIT_RUNNING;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_RUNNING;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    // Automatic refresh timebase: counts down, fires at zero and reloads.
    always_ff @(posedge clock) begin
        if (reset || !w_period_run || (r_period == '0)) begin
            r_period <= PeriodLoad;
        end else begin
            r_period <= r_period - 1'b1;
        end
    end

    // Single-entry trigger queue; a new trigger wins over consumption so a
    // trigger arriving as Idle leaves re-arms it instead of being lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_lost_running) begin
            r_pending <= 1'b0;
        end else if (w_trigger) begin
            r_pending <= 1'b1;
        end else if (w_consume) begin
            r_pending <= 1'b0;
        end
    end

    // Sticky status flags; a setting event beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_overrun <= w_overrun_set || (r_overrun && !clear);
            r_fault   <= w_fault_set   || (r_fault   && !clear);
        end
    end

    assign refresh     = r_refresh;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;
    assign fault       = r_fault;
    assign ready       = (r_state == ST_IDLE);

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Testbench for lcd_refresh_scheduler: a behavioural LCD controller answers
// refresh pulses with a busy window; expected refresh and frame_done events
// are queued as stimulus is applied and matched as the DUT produces them.
module tb_lcd_refresh_scheduler;

    localparam int RPC = 100;
    localparam int STC = 4;
    localparam int FTC = 50;
    localparam int FCW = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic           request;
    logic           clear;
    logic           lcd_configuring;
    logic           lcd_running;
    logic           lcd_busy;
    logic           refresh;
    logic           frame_done;
    logic [FCW-1:0] frame_count;
    logic           overrun;
    logic           fault;
    logic           ready;

    lcd_refresh_scheduler #(
        .RefreshPeriodCount(RPC),
        .StartTimeoutCount (STC),
        .FrameTimeoutCount (FTC),
        .FrameCountWidth   (FCW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .request        (request),
        .clear          (clear),
        .lcd_configuring(lcd_configuring),
        .lcd_running    (lcd_running),
        .lcd_busy       (lcd_busy),
        .refresh        (refresh),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .overrun        (overrun),
        .fault          (fault),
        .ready          (ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } done_t;

    int    exp_refresh_q[$];
    done_t exp_done_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int model_respond = 1;
    int model_len     = 15;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Matches this cycle's output events against the scoreboard.
    task automatic monitor();
        int    e;
        done_t d;
        if (refresh) begin
            if (exp_refresh_q.size() == 0) begin
                chk("refresh_unexpected", cyc, -1);
            end else begin
                e = exp_refresh_q.pop_front();
                chk("refresh_cycle", cyc, e);
            end
        end
        if (frame_done) begin
            if (exp_done_q.size() == 0) begin
                chk("frame_done_unexpected", cyc, -1);
            end else begin
                d = exp_done_q.pop_front();
                chk("frame_done_cycle", cyc, d.cyc);
                chk("frame_done_count", frame_count, d.cnt);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        monitor();
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // Refresh at cycle r; the model answers so the frame completes at r+18.
    task automatic push_frame(input int r, input int cnt);
        done_t d;
        exp_refresh_q.push_back(r);
        d.cyc = r + 18;
        d.cnt = cnt;
        exp_done_q.push_back(d);
    endtask

    task automatic chk_queues_empty(input string tag);
        chk({tag, "_refresh_q"}, exp_refresh_q.size(), 0);
        chk({tag, "_done_q"}, exp_done_q.size(), 0);
    endtask

    // Behavioural controller: busy rises two cycles after refresh and falls
    // model_len cycles later.
    initial begin
        lcd_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (refresh && model_respond != 0) begin
                @(posedge clock);
                @(posedge clock);
                #1 lcd_busy = 1'b1;
                repeat (model_len) @(posedge clock);
                #1 lcd_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int e;
        reset           = 1'b1;
        enable          = 1'b0;
        request         = 1'b0;
        clear           = 1'b0;
        lcd_configuring = 1'b0;
        lcd_running     = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_refresh", refresh, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ready", ready, 0);
        reset       = 1'b0;
        lcd_running = 1'b1;
        step();
        chk("ready_after_running", ready, 1);

        // Manual path
        step();
        n = cyc;
        request = 1'b1;
        push_frame(n + 2, 1);
        step();
        request = 1'b0;
        step_to(n + 3);
        chk("manual_not_ready_in_start", ready, 0);
        step_to(n + 30);
        chk("manual_frame_count", frame_count, 1);
        chk("manual_ready", ready, 1);
        chk_queues_empty("manual");

        // Automatic path
        step();
        e = cyc;
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) push_frame(e + 1 + RPC * k, 1 + k);
        step_to(e + 350);
        enable = 1'b0;
        step_to(e + 380);
        chk("auto_overrun", overrun, 0);
        chk("auto_frame_count", frame_count, 4);
        chk_queues_empty("auto");

        // Overrun: requests while a frame is in progress
        step();
        n = cyc;
        request = 1'b1;
        push_frame(n + 2, 5);
        step();
        request = 1'b0;
        step_to(n + 8);
        request = 1'b1;
        step();
        request = 1'b0;
        step_to(n + 13);
        chk("ovr_before_second", overrun, 0);
        request = 1'b1;
        step();
        request = 1'b0;
        chk("ovr_set", overrun, 1);
        step_to(n + 16);
        request = 1'b1;
        clear   = 1'b1;
        step();
        request = 1'b0;
        clear   = 1'b0;
        chk("ovr_set_beats_clear", overrun, 1);
        push_frame(n + 21, 6);
        step_to(n + 50);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_frame_count", frame_count, 6);
        chk_queues_empty("ovr");
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Start timeout: busy never rises
        model_respond = 0;
        step();
        n = cyc;
        request = 1'b1;
        exp_refresh_q.push_back(n + 2);
        step();
        request = 1'b0;
        step_to(n + 6);
        chk("start_to_fault_early", fault, 0);
        step();
        chk("start_to_fault", fault, 1);
        chk("start_to_ready", ready, 1);
        chk("start_to_frame_count", frame_count, 6);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("start_to_cleared", fault, 0);
        model_respond = 1;

        // Frame timeout: busy held for 60 cycles
        model_len = 60;
        step();
        n = cyc;
        request = 1'b1;
        exp_refresh_q.push_back(n + 2);
        step();
        request = 1'b0;
        step_to(n + 54);
        chk("frame_to_fault_early", fault, 0);
        step();
        chk("frame_to_fault", fault, 1);
        chk("frame_to_wait", ready, 0);
        step_to(n + 60);
        chk("frame_to_wait_busy", ready, 0);
        step_to(n + 66);
        chk("frame_to_idle_again", ready, 1);
        chk("frame_to_frame_count", frame_count, 6);
        chk_queues_empty("frame_to");
        model_len = 15;
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Loss of running during Busy with a trigger pending
        step();
        n = cyc;
        request = 1'b1;
        exp_refresh_q.push_back(n + 2);
        step();
        request = 1'b0;
        step_to(n + 8);
        request = 1'b1;
        step();
        request = 1'b0;
        step_to(n + 10);
        lcd_running = 1'b0;
        step();
        chk("lost_run_wait", ready, 0);
        step_to(n + 20);
        lcd_running = 1'b1;
        step_to(n + 22);
        chk("lost_run_idle", ready, 1);
        step_to(n + 35);
        chk("lost_run_frame_count", frame_count, 6);
        chk_queues_empty("lost_run");

        // Reset mid-frame with busy high
        model_len = 40;
        step();
        n = cyc;
        request = 1'b1;
        exp_refresh_q.push_back(n + 2);
        step();
        request = 1'b0;
        step_to(n + 8);
        request = 1'b1;
        step();
        step();
        request = 1'b0;
        chk("mid_rst_overrun_before", overrun, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_refresh", refresh, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_ready", ready, 0);
        step();
        reset = 1'b0;
        step_to(n + 40);
        chk("mid_rst_wait_busy", ready, 0);
        step_to(n + 47);
        chk("mid_rst_idle", ready, 1);
        chk_queues_empty("mid_rst");
        model_len = 15;

        // Normal operation after reset
        step();
        n = cyc;
        request = 1'b1;
        push_frame(n + 2, 1);
        step();
        request = 1'b0;
        step_to(n + 30);
        chk("post_rst_frame_count", frame_count, 1);
        chk_queues_empty("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
